// File: rtl/score_keeper.sv
// Match controller: edge-detects score strobes, keeps saturating 0..WIN_SCORE digits, sequences idle/rally/pause/game-over.
// Optional START_SYNC_EN: two-flop synchronizer on start ahead of its edge detector.
module score_keeper #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned PAUSE_CYCLES = 50_000_000
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic       start,
  input  logic       score_p1_in,
  input  logic       score_p2_in,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       ball_hold,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       point_flash
);

  localparam int unsigned CW  = $clog2(PAUSE_CYCLES + 1);
  localparam logic [3:0]  WIN = 4'(WIN_SCORE);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, GAME_OVER} state_t;

  state_t        state_q, state_d;
  logic [3:0]    p1_d, p2_d;
  logic [1:0]    winner_d;
  logic [CW-1:0] pause_cnt, pause_cnt_d;
  logic          s1_q, s2_q, start_q;
  logic          start_sync;
  logic          p1_edge, p2_edge, start_edge;
  logic [3:0]    p1_inc, p2_inc;

`ifdef START_SYNC_EN
  logic start_meta;
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
    end else begin
      start_meta <= start;
      start_sync <= start_meta;
    end
  end
`else
  assign start_sync = start;
`endif

  assign p1_edge    = score_p1_in & ~s1_q;
  assign p2_edge    = score_p2_in & ~s2_q;
  assign start_edge = start_sync & ~start_q;

  assign p1_inc = (p1_edge && p1_score < WIN) ? p1_score + 4'd1 : p1_score;
  assign p2_inc = (p2_edge && p2_score < WIN) ? p2_score + 4'd1 : p2_score;

  always_comb begin
    state_d     = state_q;
    p1_d        = p1_score;
    p2_d        = p2_score;
    winner_d    = winner;
    pause_cnt_d = pause_cnt;
    unique case (state_q)
      IDLE: begin
        p1_d     = '0;
        p2_d     = '0;
        winner_d = '0;
        if (start_edge) state_d = PLAY;
      end
      PLAY: begin
        if (p1_edge || p2_edge) begin
          p1_d = p1_inc;
          p2_d = p2_inc;
          if (p1_inc == WIN || p2_inc == WIN) begin
            winner_d = {p2_inc == WIN, p1_inc == WIN};
            state_d  = GAME_OVER;
          end else begin
            pause_cnt_d = CW'(PAUSE_CYCLES - 1);
            state_d     = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (pause_cnt == '0) state_d = PLAY;
        else pause_cnt_d = pause_cnt - CW'(1);
      end
      GAME_OVER: begin
        if (start_edge) begin
          p1_d     = '0;
          p2_d     = '0;
          winner_d = '0;
          state_d  = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they share the state's edge.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      p1_score    <= '0;
      p2_score    <= '0;
      winner      <= '0;
      pause_cnt   <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      start_q     <= 1'b0;
      ball_hold   <= 1'b1;
      game_over   <= 1'b0;
      point_flash <= 1'b0;
    end else begin
      state_q     <= state_d;
      p1_score    <= p1_d;
      p2_score    <= p2_d;
      winner      <= winner_d;
      pause_cnt   <= pause_cnt_d;
      s1_q        <= score_p1_in;
      s2_q        <= score_p2_in;
      start_q     <= start_sync;
      ball_hold   <= (state_d != PLAY);
      game_over   <= (state_d == GAME_OVER);
      point_flash <= (state_d == PAUSE);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper (WIN_SCORE=3, PAUSE_CYCLES=4) with a behavioural match model.
module tb_score_keeper;
  localparam int unsigned WIN   = 3;
  localparam int unsigned PAUSE = 4;

  logic       clk_50 = 1'b0;
  logic       reset, start, score_p1_in, score_p2_in;
  logic [3:0] p1_score, p2_score;
  logic       ball_hold, game_over, point_flash;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  score_keeper #(.WIN_SCORE(WIN), .PAUSE_CYCLES(PAUSE)) dut (
    .clk_50(clk_50), .reset(reset), .start(start),
    .score_p1_in(score_p1_in), .score_p2_in(score_p2_in),
    .p1_score(p1_score), .p2_score(p2_score), .ball_hold(ball_hold),
    .game_over(game_over), .winner(winner), .point_flash(point_flash)
  );

  always #10 clk_50 = ~clk_50;

  // Model: match started?, match over?, freeze cycles remaining, scores.
  int         m_p1, m_p2, m_hold;
  bit         m_started, m_over;
  logic [1:0] m_win;
  bit         m_prev1, m_prev2, m_prevs, m_sd1, m_sd2;

  task automatic model_reset();
    m_p1 = 0; m_p2 = 0; m_hold = 0; m_started = 0; m_over = 0; m_win = 2'b00;
    m_prev1 = 0; m_prev2 = 0; m_prevs = 0; m_sd1 = 0; m_sd2 = 0;
  endtask

  task automatic model_step();
    bit r1, r2, rs, st;
`ifdef START_SYNC_EN
    st = m_sd2; m_sd2 = m_sd1; m_sd1 = start;
`else
    st = start;
`endif
    r1 = score_p1_in && !m_prev1;
    r2 = score_p2_in && !m_prev2;
    rs = st && !m_prevs;
    m_prev1 = score_p1_in; m_prev2 = score_p2_in; m_prevs = st;
    if (!m_started) begin
      if (rs) m_started = 1;
    end else if (m_over) begin
      if (rs) begin m_p1 = 0; m_p2 = 0; m_win = 2'b00; m_over = 0; end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (r1 || r2) begin
      m_p1 += int'(r1); m_p2 += int'(r2);
      if (m_p1 == WIN || m_p2 == WIN) begin
        m_over = 1;
        m_win  = {m_p2 == WIN, m_p1 == WIN};
      end else m_hold = PAUSE;
    end
  endtask

  function automatic logic [12:0] exp_vec();
    bit hold, flash;
    hold  = !m_started || m_over || m_hold > 0;
    flash = m_started && !m_over && m_hold > 0;
    return {4'(m_p1), 4'(m_p2), hold, m_over, m_win, flash};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {p1_score, p2_score, ball_hold, game_over, winner, point_flash};
  endfunction

  task automatic cycle(input logic a, input logic b, input logic s);
    @(negedge clk_50);
    score_p1_in = a; score_p2_in = b; start = s;
    @(posedge clk_50);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; score_p1_in = 0; score_p2_in = 0;
    #3;
    model_reset();
    checks++;
    if (dut_vec() !== 13'b0000_0000_1_0_00_0) begin
      errors++; $display("FAIL reset_state got %h want %h", dut_vec(), 13'b0000_0000_1_0_00_0);
    end
    @(negedge clk_50) reset = 1'b0;
  endtask

  task automatic test_start();
    int lat, want;
`ifdef START_SYNC_EN
    want = 3;
`else
    want = 1;
`endif
    cycle(0, 0, 1);
    lat = 1;
    while (ball_hold !== 1'b0 && lat < 8) begin cycle(0, 0, 0); lat++; end
    checks++;
    if (lat != want) begin errors++; $display("FAIL start_latency got %0d want %0d", lat, want); end
    checks++;
    if (dut_vec() !== 13'b0000_0000_0_0_00_0) begin
      errors++; $display("FAIL start_state got %h want %h", dut_vec(), 13'b0000_0000_0_0_00_0);
    end
  endtask

  task automatic test_hold_level();
    int hold_cnt = 0, flash_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      if (i == 0) begin
        checks++;
        if (p1_score !== 4'd1) begin errors++; $display("FAIL first_point got %0d want 1", p1_score); end
      end
      hold_cnt  += int'(ball_hold);
      flash_cnt += int'(point_flash);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL hold_level_model cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    cycle(0, 0, 0);
    checks++;
    if (hold_cnt != PAUSE) begin errors++; $display("FAIL pause_hold_len got %0d want %0d", hold_cnt, PAUSE); end
    checks++;
    if (flash_cnt != PAUSE) begin errors++; $display("FAIL pause_flash_len got %0d want %0d", flash_cnt, PAUSE); end
    checks++;
    if (p1_score !== 4'd1) begin errors++; $display("FAIL no_double_count got %0d want 1", p1_score); end
  endtask

  task automatic test_simultaneous();
    cycle(0, 1, 0);
    repeat (5) cycle(0, 0, 0);
    cycle(1, 1, 0);
    checks++;
    if ({p1_score, p2_score, point_flash, ball_hold} !== {4'd2, 4'd2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL both_2_2 got %0d/%0d flash %b want 2/2 flash 1", p1_score, p2_score, point_flash);
    end
    repeat (5) cycle(0, 0, 0);
    cycle(1, 1, 0);
    checks++;
    if ({p1_score, p2_score, game_over, winner} !== {4'd3, 4'd3, 1'b1, 2'b11}) begin
      errors++; $display("FAIL both_win got %0d/%0d go %b win %b want 3/3 go 1 win 11",
                         p1_score, p2_score, game_over, winner);
    end
    cycle(0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin errors++; $display("FAIL simul_model got %h want %h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_p2_win();
    cycle(0, 0, 1);
    repeat (3) cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0);
      repeat (5) cycle(0, 0, 0);
    end
    checks++;
    if ({p1_score, p2_score, game_over, winner} !== {4'd0, 4'd3, 1'b1, 2'b10}) begin
      errors++; $display("FAIL p2_win got %0d/%0d go %b win %b want 0/3 go 1 win 10",
                         p1_score, p2_score, game_over, winner);
    end
    for (int i = 0; i < 3; i++) begin cycle(1, 1, 0); cycle(0, 0, 0); end
    checks++;
    if ({p1_score, p2_score, winner} !== {4'd0, 4'd3, 2'b10}) begin
      errors++; $display("FAIL frozen_after_win got %0d/%0d win %b want 0/3 win 10", p1_score, p2_score, winner);
    end
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    checks++;
    if ({p1_score, p2_score, winner, ball_hold, game_over} !== {4'd0, 4'd0, 2'b00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL restart got %0d/%0d win %b hold %b want 0/0 win 00 hold 0",
                         p1_score, p2_score, winner, ball_hold);
    end
  endtask

  task automatic test_reset_mid_pause();
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    #3 reset = 1'b1;
    #1 model_reset();
    checks++;
    if ({p1_score, p2_score, ball_hold, point_flash, game_over} !== {4'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL async_reset got %0d/%0d hold %b flash %b want 0/0 hold 1 flash 0",
                         p1_score, p2_score, ball_hold, point_flash);
    end
    @(negedge clk_50) reset = 1'b0;
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    checks++;
    if ({p1_score, ball_hold, point_flash} !== {4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL idle_ignores_score got p1 %0d hold %b want p1 0 hold 1", p1_score, ball_hold);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle(logic'($urandom_range(2) == 0), logic'($urandom_range(2) == 0), logic'($urandom_range(9) == 0));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_model cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if ($urandom_range(149) == 0) begin
        #2 reset = 1'b1;
        #1 model_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL random_reset cyc %0d got %h want %h", i, dut_vec(), exp_vec());
        end
        @(negedge clk_50) reset = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hold_level();
    test_simultaneous();
    test_p2_win();
    test_reset_mid_pause();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
